cbus_arbiter: RTL

CBUS_ARBITER -- requirements
Module: cbus_arbiter

---
 rtl/common.sv | 25 ++
 rtl/cbus_rr_select.sv | 25 ++
 rtl/cbus_arbiter.sv | 54 +++++
 3 files changed

// File: rtl/common.sv
// common: cache-bus types and arbiter constants shared across the cache subsystem
package common;
    typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;
    typedef logic [7:0] mlen_t;
    localparam mlen_t MLEN1 = 8'd0;
    localparam mlen_t MLEN8 = 8'd7;
    localparam mlen_t MLEN16 = 8'd15;
    typedef struct packed {
        logic        valid;
        logic        is_write;
        msize_t      size;
        logic [63:0] addr;
        mlen_t       len;
        logic [1:0]  burst;
        logic [63:0] data;
        logic [7:0]  strobe;
    } cbus_req_t;
    typedef struct packed {
        logic        ready;
        logic        last;
        logic [63:0] data;
    } cbus_resp_t;
    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
    localparam int CBUS_ARB_INPUTS = 2;
endpackage

// File: rtl/cbus_rr_select.sv
// cbus_rr_select: combinational round-robin pick, first valid index after last
module cbus_rr_select #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] valid,
    input  logic [W-1:0] last,
    output logic         any,
    output logic [W-1:0] winner
);
    int best;
    // keep the valid index with the smallest distance past last
    always_comb begin
        any = 1'b0;
        winner = '0;
        best = N;
        for (int j = 0; j < N; j++) begin
            if (valid[j] && ((j + N - 1 - int'(last)) % N) < best) begin
                any = 1'b1;
                best = (j + N - 1 - int'(last)) % N;
                winner = W'(j);
            end
        end
    end
endmodule

// File: rtl/cbus_arbiter.sv
// cbus_arbiter: round-robin N-to-1 cache-bus arbiter holding one owner per transaction
module cbus_arbiter import common::*; #(
    parameter int NUM_INPUTS = CBUS_ARB_INPUTS
) (
    input  logic       clk,
    input  logic       reset,
    input  cbus_req_t  ireqs [NUM_INPUTS],
    output cbus_resp_t iresps [NUM_INPUTS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);
    localparam int W = NUM_INPUTS > 1 ? $clog2(NUM_INPUTS) : 1;
    arb_state_t state, state_n;
    logic [W-1:0] sel, last, winner;
    logic [NUM_INPUTS-1:0] valids;
    logic any;
    for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_valid
        assign valids[g] = ireqs[g].valid;
    end
    cbus_rr_select #(.N(NUM_INPUTS), .W(W)) u_rr (
        .valid (valids),
        .last  (last),
        .any   (any),
        .winner(winner)
    );
    // state, owner and round-robin pointer; a grant is only taken from IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARB_IDLE;
            sel <= '0;
            last <= W'(NUM_INPUTS - 1);
        end else begin
            state <= state_n;
            if (state == ARB_IDLE && any) begin
                sel <= winner;
                last <= winner;
            end
        end
    end
    // ownership ends on the final beat or when the owner withdraws its request
    always_comb begin
        state_n = state;
        if (state == ARB_IDLE)
            state_n = any ? ARB_BUSY : ARB_IDLE;
        else if ((oresp.ready && oresp.last) || !ireqs[sel].valid)
            state_n = ARB_IDLE;
    end
    // connect the owner straight through; everyone else sees zeros
    always_comb begin
        oreq = state == ARB_BUSY ? ireqs[sel] : '0;
        for (int i = 0; i < NUM_INPUTS; i++)
            iresps[i] = (state == ARB_BUSY && int'(sel) == i) ? oresp : '0;
    end
endmodule
